// File: rtl/irq_scheduler.sv
// irq_scheduler: latches peripheral interrupt edges, picks one by priority and tracks its handshake with the pipeline.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; default build uses fixed lowest-index-first priority.
module irq_scheduler #(
   parameter int          NSRC      = 4,
   parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] src,
   input  logic            MemRd,
   input  logic            MemWr,
   input  logic [31:0]     Addr,
   input  logic [31:0]     WriteData,
   output logic [31:0]     ReadData,
   input  logic            kernel,
   output logic            irq_req,
   input  logic            irq_ack,
   output logic [2:0]      irq_id
);
   typedef enum logic [1:0] {IDLE, REQ, ENTER, SERVICE} state_t;
   state_t state, state_nx;
   logic [NSRC-1:0] src_q, pend, mask, act, w1c, clr;
   logic [7:0] act8;
   logic [2:0] cause_id, win;
   logic cause_v, hit_pend, hit_mask, hit_cause, ack, unused_ok;
   assign hit_pend  = Addr == BASE_ADDR;
   assign hit_mask  = Addr == BASE_ADDR + 32'd4;
   assign hit_cause = Addr == BASE_ADDR + 32'd8;
   assign act       = pend & mask;
   assign act8      = 8'(act);
   assign ack       = state == REQ && irq_ack;
   assign w1c       = MemWr && hit_pend ? WriteData[NSRC-1:0] : '0;
   assign clr       = ack ? NSRC'(1) << irq_id : '0;
   assign irq_req   = state == REQ;
   assign unused_ok = &{1'b0, WriteData[31:NSRC]};
   assign ReadData  = !MemRd    ? '0 :
                      hit_pend  ? 32'(pend) :
                      hit_mask  ? 32'(mask) :
                      hit_cause ? {cause_v, 28'b0, cause_id} : '0;
`ifdef IRQ_ROUND_ROBIN_EN
   logic [2:0] ptr;
   logic [2*NSRC-1:0] rot;
   // Rotate the active set so the search starts at ptr; bit k maps back to (ptr+k) mod NSRC.
   assign rot = {act, act} >> ptr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr <= '0;
      else if (ack) ptr <= 3'((int'(irq_id) + 1) % NSRC);
   always_comb begin
      win = '0;
      for (int k = NSRC - 1; k >= 0; k--)
         if (rot[k]) win = 3'((int'(ptr) + k) % NSRC);
   end
`else
   always_comb begin
      win = '0;
      for (int k = NSRC - 1; k >= 0; k--)
         if (act[k]) win = 3'(k);
   end
`endif
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|act && !kernel) state_nx = REQ;
         REQ:     if (irq_ack) state_nx = ENTER;
                  else if (!act8[irq_id]) state_nx = IDLE;
         ENTER:   if (kernel) state_nx = SERVICE;
         SERVICE: if (!kernel) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // A new edge on a bit being cleared (by W1C or ack) keeps it pending.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         src_q    <= '0;
         pend     <= '0;
         mask     <= '0;
         cause_v  <= 1'b0;
         cause_id <= '0;
         irq_id   <= '0;
      end else begin
         state <= state_nx;
         src_q <= src;
         pend  <= (pend & ~w1c & ~clr) | (src & ~src_q);
         if (MemWr && hit_mask) mask <= WriteData[NSRC-1:0];
         if (state == IDLE && state_nx == REQ) irq_id <= win;
         if (ack) begin
            cause_v  <= 1'b1;
            cause_id <= irq_id;
         end else if (state == SERVICE && !kernel) cause_v <= 1'b0;
      end
endmodule

// File: tb/tb_irq_scheduler.sv
// tb_irq_scheduler: scenario tasks for irq_scheduler with an expected-id scoreboard queue.
module tb_irq_scheduler;
   localparam logic [31:0] PEND_A = 32'h40000030, MASK_A = 32'h40000034, CAUSE_A = 32'h40000038;
   logic clk = 0, reset = 0, MemRd = 0, MemWr = 0, kernel = 0, irq_ack = 0, irq_req;
   logic [3:0] src = 0;
   logic [31:0] Addr = 0, WriteData = 0, ReadData, d;
   logic [2:0] irq_id, e;
   bit ok;
   int checks = 0, errors = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   irq_scheduler dut (.clk(clk), .reset(reset), .src(src), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
                      .WriteData(WriteData), .ReadData(ReadData), .kernel(kernel), .irq_req(irq_req),
                      .irq_ack(irq_ack), .irq_id(irq_id));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      MemWr = 1; Addr = a; WriteData = v;
      tick();
      MemWr = 0; Addr = 0; WriteData = 0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      MemRd = 1; Addr = a;
      #1 v = ReadData;
      MemRd = 0; Addr = 0;
   endtask

   task automatic wait_req(output bit got);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         got = irq_req;
      end
   endtask

   task automatic do_service();
      irq_ack = 1; tick(); irq_ack = 0;
      kernel = 1; tick();
      kernel = 0; tick();
   endtask

   task automatic do_reset();
      tick(); reset = 0; tick(); tick(); reset = 1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", irq_req); end
      checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", irq_id); end
      rd(PEND_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp 0", d); end
      rd(MASK_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", d); end
      rd(CAUSE_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", d); end
   endtask

   task automatic test_basic();
      wr(MASK_A, 32'hF);
      src[2] = 1; exp_q.push_back(3'd2);
      tick();
      rd(PEND_A, d);
      checks++; if (d !== 32'h4) begin errors++; $display("FAIL basic_pend got %h exp 4", d); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got %b exp 0", irq_req); end
      tick();
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", irq_req); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL basic_id got %0d exp %0d", irq_id, e); end
      irq_ack = 1; tick(); irq_ack = 0;
      rd(CAUSE_A, d);
      checks++; if (d !== 32'h80000002) begin errors++; $display("FAIL basic_cause got %h exp 80000002", d); end
      rd(PEND_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_clr got %h exp 0", d); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_enter got %b exp 0", irq_req); end
      kernel = 1; tick(); kernel = 0; tick();
      rd(CAUSE_A, d);
      checks++; if (d[31] !== 1'b0) begin errors++; $display("FAIL basic_cause_valid got %b exp 0", d[31]); end
      src = 0; tick();
   endtask

   task automatic test_priority();
      src = 4'b1010; exp_q.push_back(3'd1); exp_q.push_back(3'd3);
      for (int n = 0; n < 2; n++) begin
         wait_req(ok);
         checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got 0 exp 1"); end
         e = exp_q.pop_front();
         checks++; if (irq_id !== e) begin errors++; $display("FAIL prio_id got %0d exp %0d", irq_id, e); end
         do_service();
      end
      src = 0; tick();
   endtask

   task automatic test_mask();
      wr(MASK_A, 32'h0);
      src[0] = 1; exp_q.push_back(3'd0);
      tick(); tick();
      rd(PEND_A, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL mask_pend got %h exp 1", d); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_req_off got %b exp 0", irq_req); end
      wr(MASK_A, 32'h1);
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_req_wr got %b exp 0", irq_req); end
      tick();
      checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL mask_req_on got %b exp 1", irq_req); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL mask_id got %0d exp %0d", irq_id, e); end
      wr(PEND_A, 32'h1);
      tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL withdraw_req got %b exp 0", irq_req); end
      tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL withdraw_idle got %b exp 0", irq_req); end
      rd(PEND_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL withdraw_pend got %h exp 0", d); end
      src[0] = 0; tick(); src[0] = 1; exp_q.push_back(3'd0);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ackw1c_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL ackw1c_id got %0d exp %0d", irq_id, e); end
      irq_ack = 1; MemWr = 1; Addr = PEND_A; WriteData = 32'h1;
      tick();
      irq_ack = 0; MemWr = 0; Addr = 0; WriteData = 0;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ackw1c_req got %b exp 0", irq_req); end
      rd(CAUSE_A, d);
      checks++; if (d !== 32'h80000000) begin errors++; $display("FAIL ackw1c_cause got %h exp 80000000", d); end
      kernel = 1; tick(); kernel = 0; tick();
      src = 0; tick();
   endtask

   task automatic test_nesting();
      wr(MASK_A, 32'hF);
      src[2] = 1; exp_q.push_back(3'd2);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL nest_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL nest_id got %0d exp %0d", irq_id, e); end
      irq_ack = 1; tick(); irq_ack = 0;
      kernel = 1; tick();
      src[0] = 1; exp_q.push_back(3'd0);
      tick(); tick(); tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL nest_req_service got %b exp 0", irq_req); end
      rd(PEND_A, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL nest_pend got %h exp 1", d); end
      kernel = 0;
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL nest_late_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL nest_late_id got %0d exp %0d", irq_id, e); end
      do_service();
      src = 0; kernel = 1; tick();
      src[1] = 1; exp_q.push_back(3'd1);
      tick(); tick(); tick();
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL kernel_idle_req got %b exp 0", irq_req); end
      kernel = 0;
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL kernel_idle_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL kernel_idle_id got %0d exp %0d", irq_id, e); end
      do_service();
      src = 0; tick();
   endtask

   task automatic test_reset_in_service();
      src[3] = 1; exp_q.push_back(3'd3);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rsts_timeout got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (irq_id !== e) begin errors++; $display("FAIL rsts_id got %0d exp %0d", irq_id, e); end
      irq_ack = 1; tick(); irq_ack = 0;
      kernel = 1; tick();
      #2 reset = 0;
      #1;
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rsts_req got %b exp 0", irq_req); end
      checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL rsts_irq_id got %0d exp 0", irq_id); end
      rd(CAUSE_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsts_cause got %h exp 0", d); end
      rd(MASK_A, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsts_mask got %h exp 0", d); end
      kernel = 0;
      tick(); reset = 1;
      tick();
      rd(PEND_A, d);
      checks++; if (d !== 32'h8) begin errors++; $display("FAIL rel_edge_pend got %h exp 8", d); end
      checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rel_edge_req got %b exp 0", irq_req); end
      src[1] = 1;
      wr(PEND_A, 32'hA);
      rd(PEND_A, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL set_wins_pend got %h exp 2", d); end
      src = 0; tick();
   endtask

   task automatic test_rr();
      do_reset();
      wr(MASK_A, 32'h3);
      src = 4'b0011;
      for (int n = 0; n < 4; n++) begin
`ifdef IRQ_ROUND_ROBIN_EN
         exp_q.push_back(3'(n % 2));
`else
         exp_q.push_back(3'd0);
`endif
         wait_req(ok);
         checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got 0 exp 1"); end
         e = exp_q.pop_front();
         checks++; if (irq_id !== e) begin errors++; $display("FAIL rr_id%0d got %0d exp %0d", n, irq_id, e); end
         irq_ack = 1; tick(); irq_ack = 0;
         kernel = 1; tick();
         src = 0; tick();
         src = 4'b0011; tick();
         kernel = 0; tick();
      end
      src = 0; tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_nesting();
      test_reset_in_service();
      test_rr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
